// File: rtl/alu_seq.sv
// alu_seq: execute-stage ALU with valid/ready handshakes on both sides.
// It runs MSP430-style double-operand ops and a shift-add MUL in word or byte mode.
// It also keeps a persistent {N,Z,C,V} status register, so carry chains work across ops.
//
// Ports:
//   clk, rst_n            rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready   operation handshake (in_ready is combinational from out_ready)
//   op, op_byte           opcode (0..11 legal, 12..15 illegal) and byte-mode select
//   A, B                  operands (A = src, B = dst)
//   out_valid / out_ready result handshake, one-deep output register
//   result                registered result, bits above the active width forced to 0
//   wb_en                 result should be written back (0 for CMP, BIT and illegal ops)
//   illegal               op behind the held result was 12..15
//   flags                 status register {N,Z,C,V}
//
// WIDTH must be a multiple of 8 and at least 16.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic             op_byte,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             wb_en,
  output logic             illegal,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_DADD = 4'd5;
  localparam logic [3:0] OP_BIT  = 4'd6;
  localparam logic [3:0] OP_BIC  = 4'd7;
  localparam logic [3:0] OP_BIS  = 4'd8;
  localparam logic [3:0] OP_XOR  = 4'd9;
  localparam logic [3:0] OP_AND  = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t             state;
  logic [CW-1:0]      mul_cnt;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] mul_mcand;
  logic [WIDTH-1:0]   mul_mplier;
  logic               mul_byte;

  logic [WIDTH-1:0] mask, am, bm, nam;
  logic [WIDTH-1:0] arith_a;
  logic             arith_cin;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] dsum;
  logic [5:0]       nib;
  logic             dc, dc_byte;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic             alu_wb, alu_ill;
  logic [WIDTH-1:0] mul_mask, mul_lo;
  logic             mul_hi_nz;

  // Sign bit of a value for the active width.
  function automatic logic sign_of(input logic [WIDTH-1:0] x, input logic b8);
    return b8 ? x[7] : x[WIDTH-1];
  endfunction

  // {N,Z} of an already-masked result.
  function automatic logic [1:0] nz_of(input logic [WIDTH-1:0] r, input logic b8);
    return {sign_of(r, b8), (r == '0)};
  endfunction

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);

  // Operands are masked to the active width first.
  // With the upper bits at zero, bit w of any sum is exactly the carry out of bit w-1.
  assign mask = op_byte ? {{(WIDTH-8){1'b0}}, 8'hFF} : {WIDTH{1'b1}};
  assign am   = A & mask;
  assign bm   = B & mask;
  assign nam  = ~A & mask;

  // Shared adder for ADD/ADDC/SUB/SUBC/CMP: B + (A or ~A) + carry-in.
  always_comb begin
    arith_a   = am;
    arith_cin = 1'b0;
    case (op)
      OP_ADDC:        arith_cin = flags[1];
      OP_SUB, OP_CMP: begin arith_a = nam; arith_cin = 1'b1;     end
      OP_SUBC:        begin arith_a = nam; arith_cin = flags[1]; end
      default:        ;
    endcase
    sum = {1'b0, bm} + {1'b0, arith_a} + {{WIDTH{1'b0}}, arith_cin};
  end

  // Nibble-serial BCD adder.
  // The decimal carry out of nibble 1 is the byte-mode carry.
  always_comb begin
    dc      = flags[1];
    dc_byte = 1'b0;
    dsum    = '0;
    nib     = '0;
    for (int i = 0; i < WIDTH/4; i++) begin
      nib = {2'b00, am[i*4 +: 4]} + {2'b00, bm[i*4 +: 4]} + {5'b0, dc};
      if (nib > 6'd9) begin
        nib = nib + 6'd6;
        dc  = 1'b1;
      end else begin
        dc  = 1'b0;
      end
      dsum[i*4 +: 4] = nib[3:0];
      if (i == 1) dc_byte = dc;
    end
  end

  // Single-cycle result and next flags.
  // BIC/BIS and illegal ops leave the flags untouched.
  always_comb begin
    alu_res   = '0;
    alu_flags = flags;
    alu_wb    = 1'b1;
    alu_ill   = 1'b0;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC, OP_CMP: begin
        alu_res   = sum[WIDTH-1:0] & mask;
        alu_flags = {nz_of(alu_res, op_byte),
                     op_byte ? sum[8] : sum[WIDTH],
                     (sign_of(bm, op_byte) == sign_of(arith_a, op_byte)) &&
                     (sign_of(alu_res, op_byte) != sign_of(bm, op_byte))};
        alu_wb    = (op != OP_CMP);
      end
      OP_DADD: begin
        alu_res   = dsum & mask;
        alu_flags = {nz_of(alu_res, op_byte), op_byte ? dc_byte : dc, 1'b0};
      end
      OP_BIT, OP_AND: begin
        alu_res   = am & bm;
        alu_flags = {nz_of(alu_res, op_byte), (alu_res != '0), 1'b0};
        alu_wb    = (op != OP_BIT);
      end
      OP_XOR: begin
        alu_res   = am ^ bm;
        alu_flags = {nz_of(alu_res, op_byte), (alu_res != '0),
                     sign_of(am, op_byte) & sign_of(bm, op_byte)};
      end
      OP_BIC: alu_res = nam & bm;
      OP_BIS: alu_res = am | bm;
      OP_MUL: alu_res = '0;
      default: begin
        alu_wb  = 1'b0;
        alu_ill = 1'b1;
      end
    endcase
  end

  // MUL finish values.
  // The carry flag reports a nonzero upper half of the 2w-bit product.
  assign mul_mask  = mul_byte ? {{(WIDTH-8){1'b0}}, 8'hFF} : {WIDTH{1'b1}};
  assign mul_lo    = mul_acc[WIDTH-1:0] & mul_mask;
  assign mul_hi_nz = mul_byte ? (|mul_acc[15:8]) : (|mul_acc[2*WIDTH-1:WIDTH]);

  // Control FSM plus the output register.
  // MUL can only be accepted when the output register is free or being consumed.
  // So out_valid is always low for the whole of MUL_BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mul_cnt    <= '0;
      mul_acc    <= '0;
      mul_mcand  <= '0;
      mul_mplier <= '0;
      mul_byte   <= 1'b0;
      result     <= '0;
      flags      <= 4'b0000;
      out_valid  <= 1'b0;
      wb_en      <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            if (op == OP_MUL) begin
              state      <= MUL_BUSY;
              mul_cnt    <= op_byte ? CW'(8) : CW'(WIDTH);
              mul_acc    <= '0;
              mul_mcand  <= {{WIDTH{1'b0}}, am};
              mul_mplier <= bm;
              mul_byte   <= op_byte;
              out_valid  <= 1'b0;
            end else begin
              result    <= alu_res;
              flags     <= alu_flags;
              wb_en     <= alu_wb;
              illegal   <= alu_ill;
              out_valid <= 1'b1;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        MUL_BUSY: begin
          if (mul_cnt == '0) begin
            result    <= mul_lo;
            flags     <= {nz_of(mul_lo, mul_byte), mul_hi_nz, 1'b0};
            wb_en     <= 1'b1;
            illegal   <= 1'b0;
            out_valid <= 1'b1;
            state     <= IDLE;
          end else begin
            if (mul_mplier[0]) mul_acc <= mul_acc + mul_mcand;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
